// File: rtl/system_pkg.sv
// rtl/system_pkg.sv - shared arbiter state encoding and requester indices
package system_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

    localparam logic [1:0] REQ_GAME  = 2'd0;
    localparam logic [1:0] REQ_SCORE = 2'd1;
    localparam logic [1:0] REQ_DBG   = 2'd2;
    localparam logic [1:0] REQ_ECHO  = 2'd3;

    // Round-robin successor; the 2-bit add wraps 3 back to 0.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational four-way round-robin priority picker
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       any,
    output logic [1:0] idx
);

    logic [1:0] cand;

    // Scan farthest-first so the candidate closest to ptr is the last to win.
    always_comb begin
        any  = 1'b0;
        idx  = ptr;
        cand = ptr;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin sharing of one UART transmitter
module uart_tx_arbiter
    import system_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_wr,
    input  logic                 tx_busy,
    output logic                 grant_active,
    output logic [1:0]           grant_id,
    output logic                 abort
);

    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    arb_state_e    state_q;
    logic [1:0]    ptr_q;
    logic [1:0]    owner_q;
    logic [TW-1:0] cnt_q;
    logic          last_q;
    logic [7:0]    tx_data_q;
    logic          tx_wr_q;
    logic          grant_active_q;
    logic          abort_q;

    logic          pick_any;
    logic [1:0]    pick_idx;
    logic          owner_valid;
    logic [7:0]    owner_byte;

    rr_pick4 u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign owner_valid = req_valid[owner_q];
    assign owner_byte  = req_data[{owner_q, 3'b000} +: 8];

    // Only the owner ever sees ready, and only while the UART can take a byte.
    always_comb begin
        req_ready = '0;
        if (state_q == SEND) begin
            req_ready[owner_q] = !tx_busy;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            ptr_q          <= REQ_GAME;
            owner_q        <= REQ_GAME;
            cnt_q          <= '0;
            last_q         <= 1'b0;
            tx_data_q      <= 8'h00;
            tx_wr_q        <= 1'b0;
            grant_active_q <= 1'b0;
            abort_q        <= 1'b0;
        end else begin
            tx_wr_q <= 1'b0;
            abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        owner_q        <= pick_idx;
                        grant_active_q <= 1'b1;
                        cnt_q          <= '0;
                        state_q        <= SEND;
                    end
                end
                SEND: begin
                    if (owner_valid) begin
                        if (!tx_busy) begin
                            tx_data_q <= owner_byte;
                            tx_wr_q   <= 1'b1;
                            last_q    <= req_last[owner_q];
                            cnt_q     <= '0;
                            state_q   <= WAIT_BUSY;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        abort_q        <= 1'b1;
                        grant_active_q <= 1'b0;
                        ptr_q          <= next_idx(owner_q);
                        state_q        <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_BUSY: begin
                    state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        cnt_q <= '0;
                        if (last_q) begin
                            grant_active_q <= 1'b0;
                            ptr_q          <= next_idx(owner_q);
                            state_q        <= IDLE;
                        end else begin
                            state_q <= SEND;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_data      = tx_data_q;
    assign tx_wr        = tx_wr_q;
    assign grant_active = grant_active_q;
    assign grant_id     = owner_q;
    assign abort        = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    import system_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic        grant_active;
    logic [1:0]  grant_id;
    logic        abort;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT(16), .TW(11)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_data      (tx_data),
        .tx_wr        (tx_wr),
        .tx_busy      (tx_busy),
        .grant_active (grant_active),
        .grant_id     (grant_id),
        .abort        (abort)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int busy_cnt   = 0;
    int busy_fall  = 0;
    int ga_fall    = 0;
    int abort_cnt  = 0;
    int abort_gap  = 0;
    int wr_busy    = 0;
    logic abort_ga;
    logic prev_busy;
    logic prev_ga;
    logic wr_seen;
    logic done;
    logic [3:0] hs;
    logic [8:0] rq [4][$];
    logic [9:0] log_q [$];
    logic [9:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (rq[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = rq[i][0][7:0];
                req_last[i]        = rq[i][0][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    // One clock: sample mid-cycle, then update requesters and the UART busy model after the edge.
    task automatic tick();
        @(negedge clk);
        hs      = req_valid & req_ready;
        wr_seen = tx_wr;
        if (tx_wr) begin
            log_q.push_back({grant_id, tx_data});
            if (tx_busy) wr_busy++;
        end
        prev_busy = tx_busy;
        prev_ga   = grant_active;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (hs[i] && rq[i].size() > 0) rq[i].delete(0);
        end
        if (wr_seen) busy_cnt = 10;
        else if (busy_cnt > 0) busy_cnt--;
        tx_busy = (busy_cnt != 0);
        if (prev_busy && !tx_busy) busy_fall = cyc;
        if (prev_ga && !grant_active) ga_fall = cyc;
        if (abort) begin
            abort_cnt++;
            abort_gap = cyc - busy_fall;
            abort_ga  = grant_active;
        end
        drive();
    endtask

    task automatic run_idle(input string tag, input int maxc);
        int n;
        n    = 0;
        done = 1'b0;
        while (!done && n < maxc) begin
            tick();
            n++;
            done = (rq[0].size() == 0) && (rq[1].size() == 0) && (rq[2].size() == 0) &&
                   (rq[3].size() == 0) && !grant_active && !tx_busy;
        end
        check({tag, " finished"}, 32'(done), 32'd1);
    endtask

    task automatic expect_tx(input logic [1:0] id, input logic [7:0] data);
        exp_q.push_back({id, data});
    endtask

    task automatic check_log(input string tag);
        check({tag, " tx count"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s tx[%0d]", tag, i),
                  (i < log_q.size()) ? 32'(log_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        end
        log_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int n;
        rst       = 1'b0;
        tx_busy   = 1'b0;
        req_valid = 4'hF;
        req_data  = 32'h1122_3344;
        req_last  = 4'hF;
        prev_busy = 1'b0;
        prev_ga   = 1'b0;
        abort_ga  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset tx_wr", 32'(tx_wr), 32'd0);
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset grant_active", 32'(grant_active), 32'd0);
        check("reset grant_id", 32'(grant_id), 32'd0);
        check("reset abort", 32'(abort), 32'd0);
        check("reset tx_data", 32'(tx_data), 32'd0);

        // Round robin: 0, 1, 3 pending together; 0 re-requests right after its first packet.
        rq[0].push_back(9'h1A0);
        rq[0].push_back(9'h1B0);
        rq[1].push_back(9'h1A1);
        rq[3].push_back(9'h1A3);
        drive();
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        check("first grant active", 32'(grant_active), 32'd1);
        check("first grant id", 32'(grant_id), 32'(REQ_GAME));
        run_idle("rr", 400);
        expect_tx(REQ_GAME, 8'hA0);
        expect_tx(REQ_SCORE, 8'hA1);
        expect_tx(REQ_ECHO, 8'hA3);
        expect_tx(REQ_GAME, 8'hB0);
        check_log("rr");

        // Two-byte packet from the debug requester.
        rq[2].push_back(9'h048);
        rq[2].push_back(9'h149);
        drive();
        run_idle("single", 200);
        expect_tx(REQ_DBG, 8'h48);
        expect_tx(REQ_DBG, 8'h49);
        check_log("single");
        check("single release after busy", 32'(ga_fall - busy_fall), 32'd1);

        // Packet lock: req 0 arrives after byte 1 of a 3-byte packet from req 1.
        rq[1].push_back(9'h0C1);
        rq[1].push_back(9'h0C2);
        rq[1].push_back(9'h1C3);
        drive();
        n = 0;
        while (rq[1].size() != 2 && n < 100) begin
            tick();
            n++;
        end
        check("lock first byte taken", 32'(rq[1].size()), 32'd2);
        rq[0].push_back(9'h1D0);
        drive();
        run_idle("lock", 300);
        expect_tx(REQ_SCORE, 8'hC1);
        expect_tx(REQ_SCORE, 8'hC2);
        expect_tx(REQ_SCORE, 8'hC3);
        expect_tx(REQ_GAME, 8'hD0);
        check_log("lock");

        // Timeout: req 3 sends one non-last byte then goes quiet while req 0 waits.
        abort_cnt = 0;
        rq[3].push_back(9'h0E3);
        drive();
        n = 0;
        while (rq[3].size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("timeout byte taken", 32'(rq[3].size()), 32'd0);
        rq[0].push_back(9'h1F0);
        drive();
        run_idle("timeout", 300);
        check("timeout abort pulses", 32'(abort_cnt), 32'd1);
        check("timeout abort cycle", 32'(abort_gap), 32'd17);
        check("timeout grant dropped", 32'(abort_ga), 32'd0);
        expect_tx(REQ_ECHO, 8'hE3);
        expect_tx(REQ_GAME, 8'hF0);
        check_log("timeout");

        // Reset while the 0x55 frame is still on the wire.
        rq[2].push_back(9'h055);
        rq[2].push_back(9'h156);
        drive();
        n = 0;
        while (!(tx_busy && rq[2].size() == 1) && n < 100) begin
            tick();
            n++;
        end
        tick();
        tick();
        check("midrst owner before", 32'(grant_active), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst tx_wr", 32'(tx_wr), 32'd0);
        check("midrst grant_active", 32'(grant_active), 32'd0);
        check("midrst req_ready", 32'(req_ready), 32'd0);
        repeat (3) tick();
        check("midrst no accept", 32'(rq[2].size()), 32'd1);
        check("midrst ready held", 32'(req_ready), 32'd0);
        rst = 1'b1;
        run_idle("midrst", 300);
        expect_tx(REQ_DBG, 8'h55);
        expect_tx(REQ_DBG, 8'h56);
        check_log("midrst");

        check("tx_wr while busy", 32'(wr_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
